mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB back end of the 5-stage pipeline. Accepts the EX/MEM bundle and runs the
//  data-memory access through a ready handshake. Registers the writeback result and
//  drives the register-file write port (rd_old, reg_write_old, write_data) that the
//  decode stage consumes. Also generates decode's stall: load-use hazards and
//  memory wait cycles.
// PARAMETERS
//  DATA_W  32  datapath / memory word width
//  REG_AW  5   register index width
//  CTRL_W  9   control bundle width: [8]RegDst [7:5]ALUOp [4]ALUSrc [3]MemRead
//              [2]MemWrite [1]RegWrite [0]MemtoReg
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       synchronous reset, active low
//  exm_valid       in   1       EX/MEM bundle valid this cycle
//  exm_ctrl        in   CTRL_W  control bundle of the EX/MEM instruction
//  exm_alu         in   DATA_W  ALU result / memory address
//  exm_store       in   DATA_W  store data (rt value)
//  exm_rd          in   REG_AW  destination register
//  ex_memread      in   1       MemRead of the instruction now in EX
//  ex_rd           in   REG_AW  destination of the instruction now in EX
//  id_rs, id_rt    in   REG_AW  source fields of the instruction now in ID (IF_ID[25:21], [20:16])
//  dmem_addr       out  DATA_W  memory address
//  dmem_wdata      out  DATA_W  memory write data
//  dmem_re/dmem_we out  1 each  read / write request, held until dmem_ready
//  dmem_rdata      in   DATA_W  read data, valid when dmem_ready=1
//  dmem_ready      in   1       access complete this cycle
//  rd_old          out  REG_AW  writeback register index
//  reg_write_old   out  1       writeback enable, one cycle per retired instruction
//  write_data      out  DATA_W  writeback data
//  stall           out  1       freeze IF/ID and zero decode control (combinational)
//  exm_ready       out  1       stage can accept a bundle this cycle
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: dmem_re, dmem_we, dmem_addr, dmem_wdata,
//    rd_old, reg_write_old, write_data. exm_ready=1.
//  - FSM states:
//    - IDLE: accept when exm_valid.
//      - MemRead or MemWrite set: latch bundle, drive dmem_* next cycle, go to ACCESS.
//      - Otherwise: go to WB with write_data=exm_alu.
//    - ACCESS: hold dmem_* stable until dmem_ready=1. On ready, capture dmem_rdata,
//      drop requests next cycle, go to WB.
//    - WB: pulse reg_write_old for one cycle. Accept a new bundle in the same cycle
//      (same rules as IDLE), else go to IDLE.
//  - exm_ready=1 in IDLE and WB, 0 in ACCESS.
//  - Latency: ALU op accepted at edge N -> reg_write_old high in cycle N+1.
//    Memory op: dmem_ready seen in cycle M -> writeback in cycle M+1.
//  - write_data = MemtoReg ? captured dmem_rdata : latched exm_alu.
//  - reg_write_old = RegWrite & ~MemWrite & (rd_old != 0). Register 0 is never written.
//  - If MemRead and MemWrite are both set, MemRead wins and no write is issued.
//  - stall = (state==ACCESS & ~dmem_ready)
//          | (ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)).
//  - dmem_ready outside ACCESS is ignored.
//  - exm_valid while exm_ready=0 is a protocol error; the bundle is dropped.
//  - Reset mid-ACCESS: requests drop at that edge, no writeback, state=IDLE.
// CONFIGURATION
//  STALL_COUNT_EN defined:
//  - Adds output stall_cnt[31:0], cleared by reset, +1 on every cycle with stall=1.
//  - Saturates at 32'hFFFF_FFFF.
//  STALL_COUNT_EN undefined: the port and counter are absent; all other behaviour
//  is identical.
// TESTING
//  - ALU writeback: bundle ctrl=9'h002, alu=32'h1234, rd=5 -> next cycle
//    reg_write_old=1, rd_old=5, write_data=32'h1234. No dmem activity.
//  - Load with wait states: ctrl=9'h00B, alu=32'h40, dmem_ready low 3 cycles then
//    rdata=32'hCAFE -> dmem_re=1 with addr=32'h40 for 4 cycles, stall=1 for 3,
//    write_data=32'hCAFE one cycle later.
//  - Store: ctrl=9'h004, store=32'h55 -> dmem_we=1, wdata=32'h55 until ready;
//    reg_write_old stays 0.
//  - rd=0 writeback: ALU op rd=0 -> reg_write_old=0.
//  - Load-use: ex_memread=1, ex_rd=7, id_rt=7 -> stall=1 that cycle.
//    Same with ex_rd=0 -> stall=0.
//  - Reset in ACCESS: assert rst_n=0 while dmem_re=1 -> next cycle dmem_re=0,
//    no writeback, exm_ready=1. With STALL_COUNT_EN: stall_cnt=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_wb_stage                                               |
// | Description : MEM/WB back end of the 5-stage pipeline. Runs the data     |
// |               memory access through a ready handshake, registers the     |
// |               writeback result for the register file and raises decode's |
// |               stall on load-use hazards and memory wait cycles.          |
// | Options     : STALL_COUNT_EN adds a saturating stall_cnt[31:0] output.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exm_valid,
  input  logic [CTRL_W-1:0] exm_ctrl,
  input  logic [DATA_W-1:0] exm_alu,
  input  logic [DATA_W-1:0] exm_store,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_re,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [REG_AW-1:0] rd_old,
  output logic              reg_write_old,
  output logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              exm_ready
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Control bundle bit positions
  localparam int C_MEMREAD  = 3;
  localparam int C_MEMWRITE = 2;
  localparam int C_REGWRITE = 1;
  localparam int C_MEMTOREG = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              dmem_re_q, dmem_re_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [REG_AW-1:0] rd_old_q, rd_old_d;
  logic              reg_write_old_q, reg_write_old_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  // Writeback qualifiers of the instruction waiting on memory
  logic              pend_wen_q, pend_wen_d;
  logic              pend_m2r_q, pend_m2r_d;

  logic w_accept;
  logic w_is_mem;
  logic w_rd_nz;
  logic w_load_use;
  logic w_unused_ctrl;

  // Only the memory/writeback control bits matter in this stage
  assign w_unused_ctrl = ^exm_ctrl[CTRL_W-1:4];

  assign exm_ready  = (state_q != ST_ACCESS);
  assign w_accept   = exm_valid & exm_ready;
  assign w_is_mem   = exm_ctrl[C_MEMREAD] | exm_ctrl[C_MEMWRITE];
  assign w_rd_nz    = (exm_rd != '0);
  assign w_load_use = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign stall      = ((state_q == ST_ACCESS) & ~dmem_ready) | w_load_use;

  // Next-state and datapath: accept bundles, run the access, produce the writeback
  always_comb begin
    state_d         = state_q;
    dmem_re_d       = dmem_re_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    rd_old_d        = rd_old_q;
    reg_write_old_d = 1'b0;
    write_data_d    = write_data_q;
    pend_wen_d      = pend_wen_q;
    pend_m2r_d      = pend_m2r_q;
    case (state_q)
      ST_ACCESS: begin
        if (dmem_ready) begin
          dmem_re_d       = 1'b0;
          dmem_we_d       = 1'b0;
          write_data_d    = pend_m2r_q ? dmem_rdata : dmem_addr_q;
          reg_write_old_d = pend_wen_q;
          state_d         = ST_WB;
        end
      end
      default: begin
        if (w_accept) begin
          rd_old_d = exm_rd;
          if (w_is_mem) begin
            // A read wins over a simultaneous write request
            dmem_re_d    = exm_ctrl[C_MEMREAD];
            dmem_we_d    = exm_ctrl[C_MEMWRITE] & ~exm_ctrl[C_MEMREAD];
            dmem_addr_d  = exm_alu;
            dmem_wdata_d = exm_store;
            pend_wen_d   = exm_ctrl[C_REGWRITE] & ~exm_ctrl[C_MEMWRITE] & w_rd_nz;
            pend_m2r_d   = exm_ctrl[C_MEMTOREG];
            state_d      = ST_ACCESS;
          end else begin
            write_data_d    = exm_alu;
            reg_write_old_d = exm_ctrl[C_REGWRITE] & w_rd_nz;
            state_d         = ST_WB;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      dmem_re_q       <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      rd_old_q        <= '0;
      reg_write_old_q <= 1'b0;
      write_data_q    <= '0;
      pend_wen_q      <= 1'b0;
      pend_m2r_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      dmem_re_q       <= dmem_re_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      rd_old_q        <= rd_old_d;
      reg_write_old_q <= reg_write_old_d;
      write_data_q    <= write_data_d;
      pend_wen_q      <= pend_wen_d;
      pend_m2r_q      <= pend_m2r_d;
    end
  end

  assign dmem_re       = dmem_re_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign rd_old        = rd_old_q;
  assign reg_write_old = reg_write_old_q;
  assign write_data    = write_data_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_wb_stage                                            |
// | Description : Scoreboard bench for mem_wb_stage: random bundles, memory  |
// |               wait states, hazards and a reset during an access.         |
// | Options     : STALL_COUNT_EN also checks stall_cnt.                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        exm_valid;
  logic [8:0]  exm_ctrl;
  logic [31:0] exm_alu;
  logic [31:0] exm_store;
  logic [4:0]  exm_rd;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_re;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [4:0]  rd_old;
  logic        reg_write_old;
  logic [31:0] write_data;
  logic        stall;
  logic        exm_ready;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt;
`endif

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .exm_valid(exm_valid), .exm_ctrl(exm_ctrl), .exm_alu(exm_alu),
    .exm_store(exm_store), .exm_rd(exm_rd),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .rd_old(rd_old), .reg_write_old(reg_write_old), .write_data(write_data),
    .stall(stall), .exm_ready(exm_ready)
`ifdef STALL_COUNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive hazard inputs, then check stall against the hazard rule
  task automatic set_hazard(input bit m, input logic [4:0] erd, input logic [4:0] rs,
                            input logic [4:0] rt, input bit in_access, input bit rdy);
    bit lu;
    ex_memread = m; ex_rd = erd; id_rs = rs; id_rt = rt;
    #1;
    lu = m && (erd != 0) && (erd == rs || erd == rt);
    chk("stall", stall, (in_access && !rdy) || lu);
  endtask

  task automatic rand_hazard(input bit in_access, input bit rdy);
    set_hazard($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), in_access, rdy);
  endtask

  // One cycle with no bundle offered
  task automatic idle_cycle();
    exm_valid  = 1'b0;
    dmem_ready = 1'($urandom_range(0, 1));
    rand_hazard(0, 0);
    chk("exm_ready_idle", exm_ready, 1);
    @(posedge clk); @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("no_wb_after_idle", reg_write_old, 0);
  endtask

  // Offer one bundle and run it to completion; the expected writeback goes to the scoreboard
  task automatic send(input logic [8:0] ctrl, input logic [31:0] alu, input logic [31:0] st,
                      input logic [4:0] rd, input int wait_n, input logic [31:0] rdata,
                      input bit junk);
    bit mr, mw, mem, exp_we;
    logic [31:0] exp_data;
    wb_t e;
    mr       = ctrl[3];
    mw       = ctrl[2];
    mem      = mr | mw;
    exp_we   = ctrl[1] && !mw && (rd != 0);
    exp_data = (mem && ctrl[0]) ? rdata : alu;
    if (exp_we) begin
      e.rd = rd; e.data = exp_data;
      sb_q.push_back(e);
    end
    exm_valid = 1'b1; exm_ctrl = ctrl; exm_alu = alu; exm_store = st; exm_rd = rd;
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    rand_hazard(0, 0);
    chk("exm_ready_accept", exm_ready, 1);
    @(posedge clk); @(negedge clk);
    exm_valid = 1'b0; dmem_ready = 1'b0;
    if (mem) begin
      for (int i = 0; i <= wait_n; i++) begin
        dmem_ready = (i == wait_n);
        dmem_rdata = (i == wait_n) ? rdata : $urandom;
        if (junk && i == 0) begin
          // Offered while busy: must be dropped
          exm_valid = 1'b1; exm_ctrl = 9'h002; exm_rd = 5'd9; exm_alu = $urandom;
        end
        rand_hazard(1, i == wait_n);
        chk("exm_ready_access", exm_ready, 0);
        chk("dmem_re", dmem_re, mr);
        chk("dmem_we", dmem_we, mw && !mr);
        chk("dmem_addr", dmem_addr, alu);
        if (mw && !mr) chk("dmem_wdata", dmem_wdata, st);
        @(posedge clk); @(negedge clk);
        exm_valid = 1'b0; dmem_ready = 1'b0;
      end
    end
    #1;
    chk("wb_pulse", reg_write_old, exp_we);
    chk("req_drop_re", dmem_re, 0);
    chk("req_drop_we", dmem_we, 0);
  endtask

  // Writeback monitor: every pulse must match the oldest expected writeback
  always @(negedge clk) begin : wb_monitor
    wb_t e;
    #3;
    if (reg_write_old === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_wb: got rd %0d data %h expected no writeback at %0t",
                 rd_old, write_data, $time);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd", 32'(rd_old), 32'(e.rd));
        chk("wb_data", write_data, e.data);
      end
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] cnt_model = '0;
  bit prev_stall = 1'b0;
  bit prev_rst_n = 1'b0;
  bit cnt_started = 1'b0;
  // Counter model: cleared by reset, +1 per stalled cycle, saturating
  always @(negedge clk) begin
    #3;
    if (cnt_started) begin
      if (!prev_rst_n) cnt_model = '0;
      else if (prev_stall && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 1;
      chk("stall_cnt", stall_cnt, cnt_model);
    end
    prev_stall  = stall;
    prev_rst_n  = rst_n;
    cnt_started = 1'b1;
  end
`endif

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; exm_valid = 1'b0; exm_ctrl = '0; exm_alu = '0; exm_store = '0;
    exm_rd = '0; ex_memread = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dmem_re", dmem_re, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_rd_old", 32'(rd_old), 0);
    chk("rst_reg_write_old", reg_write_old, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_exm_ready", exm_ready, 1);
    rst_n = 1'b1;

    // Directed cases
    send(9'h002, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 0);
    send(9'h00B, 32'h40, 32'h0, 5'd2, 3, 32'hCAFE, 0);
    send(9'h004, 32'h44, 32'h55, 5'd6, 2, 32'h0, 0);
    send(9'h002, 32'h77, 32'h0, 5'd0, 0, 32'h0, 0);
    send(9'h00E, 32'h48, 32'h99, 5'd4, 1, 32'hBEEF, 0);
    exm_valid = 1'b0;
    set_hazard(1, 5'd7, 5'd3, 5'd7, 0, 0);
    @(posedge clk); @(negedge clk);
    set_hazard(1, 5'd0, 5'd0, 5'd0, 0, 0);
    @(posedge clk); @(negedge clk);
    #1;

    // Reset while a load is waiting on memory
    exm_valid = 1'b1; exm_ctrl = 9'h00B; exm_alu = 32'h80; exm_rd = 5'd3;
    set_hazard(0, 5'd0, 5'd0, 5'd0, 0, 0);
    @(posedge clk); @(negedge clk);
    exm_valid = 1'b0; dmem_ready = 1'b0;
    set_hazard(0, 5'd0, 5'd0, 5'd0, 1, 0);
    chk("pre_rst_dmem_re", dmem_re, 1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    chk("midrst_dmem_re", dmem_re, 0);
    chk("midrst_reg_write_old", reg_write_old, 0);
    chk("midrst_exm_ready", exm_ready, 1);
`ifdef STALL_COUNT_EN
    chk("midrst_stall_cnt", stall_cnt, 0);
`endif
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      send(9'($urandom_range(0, 511)), $urandom, $urandom, 5'($urandom_range(0, 7)),
           $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
